// File: rtl/dual_issue_scheduler_pkg.sv
// Shared constants for the SPU dual-issue scheduler: geometry, unit latencies
// and the pipe encoding.
package dual_issue_scheduler_pkg;

  localparam int NUM_REGS       = 128;
  localparam int REG_ADDR_WIDTH = 7;
  localparam int LAT_WIDTH      = 3;
  localparam int INSTR_W        = 64;
  localparam int PERF_W         = 32;
  localparam int NUM_SRC        = 3;

  // Cycles until each unit's result reaches the forwarding network.
  localparam logic [LAT_WIDTH-1:0] LAT_FX1    = 3'd2;
  localparam logic [LAT_WIDTH-1:0] LAT_BYTE   = 3'd3;
  localparam logic [LAT_WIDTH-1:0] LAT_FX2    = 3'd3;
  localparam logic [LAT_WIDTH-1:0] LAT_PERM   = 3'd3;
  localparam logic [LAT_WIDTH-1:0] LAT_BRANCH = 3'd3;
  localparam logic [LAT_WIDTH-1:0] LAT_SP_FP  = 3'd6;
  localparam logic [LAT_WIDTH-1:0] LAT_LS     = 3'd6;
  localparam logic [LAT_WIDTH-1:0] LAT_SP_INT = 3'd7;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_e;

  // Countdown loaded on issue; a latency of 0 behaves like 1.
  function automatic logic [LAT_WIDTH-1:0] sb_load(input logic [LAT_WIDTH-1:0] lat);
    return (lat == '0) ? '0 : lat - LAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_issue_scoreboard.sv
// Per-register countdown array: two set ports (issuing slots), a free-running
// decrement, and six combinational busy lookups (three sources per slot).
module issue_scoreboard
  import dual_issue_scheduler_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          set_en,
  input  logic [1:0][REG_ADDR_WIDTH-1:0]      set_addr,
  input  logic [1:0][LAT_WIDTH-1:0]           set_lat,
  input  logic [2*NUM_SRC-1:0][REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [2*NUM_SRC-1:0]                rd_busy
);

  logic [LAT_WIDTH-1:0] sb_q [NUM_REGS];
  logic [LAT_WIDTH-1:0] sb_d [NUM_REGS];

  // A fresh set from an issuing slot overrides the decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = sb_q[r];
      if (sb_q[r] != '0) sb_d[r] = sb_q[r] - LAT_WIDTH'(1);
      for (int p = 0; p < 2; p++) begin
        if (set_en[p] && (set_addr[p] == REG_ADDR_WIDTH'(r))) sb_d[r] = sb_load(set_lat[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) sb_q[r] <= '0;
      else       sb_q[r] <= sb_d[r];
    end
  end

  always_comb begin
    for (int i = 0; i < 2*NUM_SRC; i++) begin
      rd_busy[i] = (sb_q[rd_addr[i]] != '0);
    end
  end

endmodule

// File: rtl/dual_issue_scheduler.sv
// SPU issue stage: picks up to two in-order decoded instructions per cycle,
// checks RAW/WAW/pipe legality and registers them onto the even/odd pipes.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [1:0]                  dec_valid,
  input  logic [1:0]                  dec_pipe,
  input  logic [INSTR_W-1:0]          dec_payload0,
  input  logic [INSTR_W-1:0]          dec_payload1,
  input  logic [3*REG_ADDR_WIDTH-1:0] dec_src_addr0,
  input  logic [3*REG_ADDR_WIDTH-1:0] dec_src_addr1,
  input  logic [2:0]                  dec_src_use0,
  input  logic [2:0]                  dec_src_use1,
  input  logic [REG_ADDR_WIDTH-1:0]   dec_rt_addr0,
  input  logic [REG_ADDR_WIDTH-1:0]   dec_rt_addr1,
  input  logic [1:0]                  dec_rt_wr,
  input  logic [LAT_WIDTH-1:0]        dec_lat0,
  input  logic [LAT_WIDTH-1:0]        dec_lat1,
  output logic [1:0]                  dec_consume,
  output logic                        even_valid,
  output logic                        odd_valid,
  output logic [INSTR_W-1:0]          even_payload,
  output logic [INSTR_W-1:0]          odd_payload,
  output logic [REG_ADDR_WIDTH-1:0]   even_rt_addr,
  output logic [REG_ADDR_WIDTH-1:0]   odd_rt_addr,
  output logic [PERF_W-1:0]           stall_cnt,
  output logic [PERF_W-1:0]           dual_cnt
);

  logic [2*NUM_SRC-1:0][REG_ADDR_WIDTH-1:0] rd_addr;
  logic [2*NUM_SRC-1:0]                     rd_busy;
  logic [2*NUM_SRC-1:0]                     rd_use;
  logic [NUM_SRC-1:0]                       hit_rt0;
  logic rdy0, rdy1, waw_hz, pipe_split, iss0, iss1, stall_inc;

  logic                      even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
  logic [INSTR_W-1:0]        even_payload_q, even_payload_d, odd_payload_q, odd_payload_d;
  logic [REG_ADDR_WIDTH-1:0] even_rt_q, even_rt_d, odd_rt_q, odd_rt_d;
  logic [PERF_W-1:0]         stall_cnt_q, stall_cnt_d, dual_cnt_q, dual_cnt_d;

  assign rd_addr = {dec_src_addr1, dec_src_addr0};
  assign rd_use  = {dec_src_use1, dec_src_use0};

  issue_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   ({iss1 & dec_rt_wr[1], iss0 & dec_rt_wr[0]}),
    .set_addr ({dec_rt_addr1, dec_rt_addr0}),
    .set_lat  ({dec_lat1, dec_lat0}),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

  // Slot1 may not read slot0's result in the same cycle: it is not yet forwardable.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      hit_rt0[k] = dec_src_use1[k] && dec_rt_wr[0] && (rd_addr[NUM_SRC+k] == dec_rt_addr0);
    end
  end

  assign rdy0       = ~|(rd_use[NUM_SRC-1:0] & rd_busy[NUM_SRC-1:0]);
  assign rdy1       = ~|(rd_use[2*NUM_SRC-1:NUM_SRC] & rd_busy[2*NUM_SRC-1:NUM_SRC]);
  assign waw_hz     = dec_rt_wr[0] && dec_rt_wr[1] && (dec_rt_addr0 == dec_rt_addr1);
  assign pipe_split = (dec_pipe[1] != dec_pipe[0]);
  assign iss0       = !reset && !flush && dec_valid[0] && rdy0;
  assign iss1       = iss0 && dec_valid[1] && rdy1 && pipe_split && !(|hit_rt0) && !waw_hz;
  assign stall_inc  = !reset && !flush && dec_valid[0] && !iss0;

  assign dec_consume = {iss1, iss0};

  always_comb begin
    even_valid_d   = 1'b0;
    odd_valid_d    = 1'b0;
    even_payload_d = even_payload_q;
    odd_payload_d  = odd_payload_q;
    even_rt_d      = even_rt_q;
    odd_rt_d       = odd_rt_q;
    if (iss0) begin
      if (pipe_e'(dec_pipe[0]) == PIPE_EVEN) begin
        even_valid_d   = 1'b1;
        even_payload_d = dec_payload0;
        even_rt_d      = dec_rt_addr0;
      end else begin
        odd_valid_d    = 1'b1;
        odd_payload_d  = dec_payload0;
        odd_rt_d       = dec_rt_addr0;
      end
    end
    if (iss1) begin
      if (pipe_e'(dec_pipe[1]) == PIPE_EVEN) begin
        even_valid_d   = 1'b1;
        even_payload_d = dec_payload1;
        even_rt_d      = dec_rt_addr1;
      end else begin
        odd_valid_d    = 1'b1;
        odd_payload_d  = dec_payload1;
        odd_rt_d       = dec_rt_addr1;
      end
    end
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    dual_cnt_d  = dual_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (iss1 && (dual_cnt_q != '1))       dual_cnt_d  = dual_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      even_valid_q   <= 1'b0;
      odd_valid_q    <= 1'b0;
      even_payload_q <= '0;
      odd_payload_q  <= '0;
      even_rt_q      <= '0;
      odd_rt_q       <= '0;
      stall_cnt_q    <= '0;
      dual_cnt_q     <= '0;
    end else begin
      even_valid_q   <= even_valid_d;
      odd_valid_q    <= odd_valid_d;
      even_payload_q <= even_payload_d;
      odd_payload_q  <= odd_payload_d;
      even_rt_q      <= even_rt_d;
      odd_rt_q       <= odd_rt_d;
      stall_cnt_q    <= stall_cnt_d;
      dual_cnt_q     <= dual_cnt_d;
    end
  end

  assign even_valid   = even_valid_q;
  assign odd_valid    = odd_valid_q;
  assign even_payload = even_payload_q;
  assign odd_payload  = odd_payload_q;
  assign even_rt_addr = even_rt_q;
  assign odd_rt_addr  = odd_rt_q;
  assign stall_cnt    = stall_cnt_q;
  assign dual_cnt     = dual_cnt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: expected pipe bundles are queued when
// a decode pair is driven and compared one cycle later against the outputs.
module tb_dual_issue_scheduler;
  import dual_issue_scheduler_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        flush;
  logic [1:0]                  dec_valid, dec_pipe, dec_rt_wr, dec_consume;
  logic [INSTR_W-1:0]          dec_payload0, dec_payload1;
  logic [3*REG_ADDR_WIDTH-1:0] dec_src_addr0, dec_src_addr1;
  logic [2:0]                  dec_src_use0, dec_src_use1;
  logic [REG_ADDR_WIDTH-1:0]   dec_rt_addr0, dec_rt_addr1;
  logic [LAT_WIDTH-1:0]        dec_lat0, dec_lat1;
  logic                        even_valid, odd_valid;
  logic [INSTR_W-1:0]          even_payload, odd_payload;
  logic [REG_ADDR_WIDTH-1:0]   even_rt_addr, odd_rt_addr;
  logic [PERF_W-1:0]           stall_cnt, dual_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic                      ev;
    logic                      ov;
    logic [INSTR_W-1:0]        ep;
    logic [INSTR_W-1:0]        op;
    logic [REG_ADDR_WIDTH-1:0] er;
    logic [REG_ADDR_WIDTH-1:0] orr;
  } bundle_t;

  bundle_t            exp_q[$];
  logic [INSTR_W-1:0] last_ep = '0;
  logic [INSTR_W-1:0] last_op = '0;

  always #5 clk = ~clk;

  dual_issue_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .dec_valid     (dec_valid),
    .dec_pipe      (dec_pipe),
    .dec_payload0  (dec_payload0),
    .dec_payload1  (dec_payload1),
    .dec_src_addr0 (dec_src_addr0),
    .dec_src_addr1 (dec_src_addr1),
    .dec_src_use0  (dec_src_use0),
    .dec_src_use1  (dec_src_use1),
    .dec_rt_addr0  (dec_rt_addr0),
    .dec_rt_addr1  (dec_rt_addr1),
    .dec_rt_wr     (dec_rt_wr),
    .dec_lat0      (dec_lat0),
    .dec_lat1      (dec_lat1),
    .dec_consume   (dec_consume),
    .even_valid    (even_valid),
    .odd_valid     (odd_valid),
    .even_payload  (even_payload),
    .odd_payload   (odd_payload),
    .even_rt_addr  (even_rt_addr),
    .odd_rt_addr   (odd_rt_addr),
    .stall_cnt     (stall_cnt),
    .dual_cnt      (dual_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearSlots();
    flush         = 1'b0;
    dec_valid     = '0;
    dec_pipe      = '0;
    dec_rt_wr     = '0;
    dec_payload0  = '0;
    dec_payload1  = '0;
    dec_src_addr0 = '0;
    dec_src_addr1 = '0;
    dec_src_use0  = '0;
    dec_src_use1  = '0;
    dec_rt_addr0  = '0;
    dec_rt_addr1  = '0;
    dec_lat0      = '0;
    dec_lat1      = '0;
  endtask

  task automatic slot0(input pipe_e pipe, input logic [6:0] rt, input logic [2:0] lat,
                       input logic [6:0] ra, input logic [6:0] rb, input logic [1:0] sel,
                       input logic [63:0] pay);
    dec_valid[0]  = 1'b1;
    dec_pipe[0]   = pipe;
    dec_rt_wr[0]  = 1'b1;
    dec_rt_addr0  = rt;
    dec_lat0      = lat;
    dec_src_addr0 = {7'd0, rb, ra};
    dec_src_use0  = {1'b0, sel};
    dec_payload0  = pay;
  endtask

  task automatic slot1(input pipe_e pipe, input logic [6:0] rt, input logic [2:0] lat,
                       input logic [6:0] ra, input logic [6:0] rb, input logic [1:0] sel,
                       input logic [63:0] pay);
    dec_valid[1]  = 1'b1;
    dec_pipe[1]   = pipe;
    dec_rt_wr[1]  = 1'b1;
    dec_rt_addr1  = rt;
    dec_lat1      = lat;
    dec_src_addr1 = {7'd0, rb, ra};
    dec_src_use1  = {1'b0, sel};
    dec_payload1  = pay;
  endtask

  task automatic checkOutput(input string tag);
    bundle_t b;
    b = exp_q.pop_front();
    chk({tag, " even_valid"},   even_valid,   b.ev);
    chk({tag, " odd_valid"},    odd_valid,    b.ov);
    chk({tag, " even_payload"}, even_payload, b.ep);
    chk({tag, " odd_payload"},  odd_payload,  b.op);
    if (b.ev) chk({tag, " even_rt"}, even_rt_addr, b.er);
    if (b.ov) chk({tag, " odd_rt"},  odd_rt_addr,  b.orr);
  endtask

  // Checks the combinational accept, queues the bundle it implies, then clocks.
  task automatic applyStimulus(input string tag, input logic [1:0] exp_cons);
    bundle_t b;
    #2;
    chk({tag, " consume"}, dec_consume, exp_cons);
    b.ev = 1'b0; b.ov = 1'b0; b.ep = last_ep; b.op = last_op; b.er = '0; b.orr = '0;
    if (exp_cons[0]) begin
      if (dec_pipe[0] == PIPE_EVEN) begin b.ev = 1'b1; b.ep = dec_payload0; b.er = dec_rt_addr0; end
      else begin b.ov = 1'b1; b.op = dec_payload0; b.orr = dec_rt_addr0; end
    end
    if (exp_cons[1]) begin
      if (dec_pipe[1] == PIPE_EVEN) begin b.ev = 1'b1; b.ep = dec_payload1; b.er = dec_rt_addr1; end
      else begin b.ov = 1'b1; b.op = dec_payload1; b.orr = dec_rt_addr1; end
    end
    last_ep = b.ep;
    last_op = b.op;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkCounters(input string tag, input int exp_stall, input int exp_dual);
    chk({tag, " stall_cnt"}, stall_cnt, 64'(exp_stall));
    chk({tag, " dual_cnt"},  dual_cnt,  64'(exp_dual));
  endtask

  task automatic checkResetState(input string tag);
    chk({tag, " even_valid"},   even_valid,   1'b0);
    chk({tag, " odd_valid"},    odd_valid,    1'b0);
    chk({tag, " even_payload"}, even_payload, 64'd0);
    chk({tag, " odd_payload"},  odd_payload,  64'd0);
    chk({tag, " even_rt"},      even_rt_addr, 64'd0);
    chk({tag, " odd_rt"},       odd_rt_addr,  64'd0);
    checkCounters(tag, 0, 0);
    last_ep = '0;
    last_op = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: observed no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    clearSlots();
    slot0(PIPE_EVEN, 7'd1, 3'd2, 7'd0, 7'd0, 2'b00, 64'hDEAD);
    @(posedge clk); #1;
    #2;
    chk("reset consume", dec_consume, 2'b00);
    @(posedge clk); #1;
    checkResetState("reset");
    reset = 1'b0;
    clearSlots();

    // Independent even/odd pair dual-issues.
    slot0(PIPE_EVEN, 7'd3, LAT_FX1, 7'd1, 7'd2, 2'b11, 64'hA0);
    slot1(PIPE_ODD,  7'd5, LAT_LS,  7'd6, 7'd0, 2'b01, 64'hA1);
    applyStimulus("dual", 2'b11);
    checkCounters("dual", 0, 1);

    // Same pipe: split into two single issues.
    clearSlots();
    slot0(PIPE_EVEN, 7'd20, 3'd2, 7'd21, 7'd0, 2'b01, 64'hB0);
    slot1(PIPE_EVEN, 7'd22, 3'd2, 7'd23, 7'd0, 2'b01, 64'hB1);
    applyStimulus("same_pipe_a", 2'b01);
    clearSlots();
    slot0(PIPE_EVEN, 7'd22, 3'd2, 7'd23, 7'd0, 2'b01, 64'hB1);
    applyStimulus("same_pipe_b", 2'b01);
    checkCounters("same_pipe", 0, 1);

    // Latency-7 producer holds its dependant for six cycles.
    clearSlots();
    slot0(PIPE_EVEN, 7'd10, LAT_SP_INT, 7'd30, 7'd0, 2'b01, 64'hC0);
    applyStimulus("prod_l7", 2'b01);
    clearSlots();
    slot0(PIPE_ODD, 7'd11, 3'd2, 7'd10, 7'd0, 2'b01, 64'hC1);
    for (int i = 0; i < 6; i++) applyStimulus("raw_wait", 2'b00);
    applyStimulus("raw_issue", 2'b01);
    checkCounters("raw", 6, 1);

    // Slot1 reads slot0's destination: L0=1 issues back-to-back.
    clearSlots();
    slot0(PIPE_EVEN, 7'd4, 3'd1, 7'd40, 7'd0, 2'b01, 64'hD0);
    slot1(PIPE_ODD,  7'd41, 3'd2, 7'd4, 7'd0, 2'b01, 64'hD1);
    applyStimulus("intra_l1", 2'b01);
    clearSlots();
    slot0(PIPE_ODD, 7'd41, 3'd2, 7'd4, 7'd0, 2'b01, 64'hD1);
    applyStimulus("intra_l1_next", 2'b01);

    // Latency 0 behaves like latency 1.
    clearSlots();
    slot0(PIPE_EVEN, 7'd80, 3'd0, 7'd81, 7'd0, 2'b01, 64'hD4);
    slot1(PIPE_ODD,  7'd82, 3'd2, 7'd80, 7'd0, 2'b01, 64'hD5);
    applyStimulus("intra_l0", 2'b01);
    clearSlots();
    slot0(PIPE_ODD, 7'd82, 3'd2, 7'd80, 7'd0, 2'b01, 64'hD5);
    applyStimulus("intra_l0_next", 2'b01);

    // Slot1 reads slot0's destination with L0=3: waits two cycles.
    clearSlots();
    slot0(PIPE_EVEN, 7'd42, LAT_PERM, 7'd44, 7'd0, 2'b01, 64'hD2);
    slot1(PIPE_ODD,  7'd43, 3'd2, 7'd0, 7'd42, 2'b10, 64'hD3);
    applyStimulus("intra_l3", 2'b01);
    clearSlots();
    slot0(PIPE_ODD, 7'd43, 3'd2, 7'd0, 7'd42, 2'b10, 64'hD3);
    applyStimulus("intra_l3_wait", 2'b00);
    applyStimulus("intra_l3_wait", 2'b00);
    applyStimulus("intra_l3_issue", 2'b01);
    checkCounters("intra", 8, 1);

    // Same destination in both slots blocks slot1.
    clearSlots();
    slot0(PIPE_EVEN, 7'd50, 3'd2, 7'd51, 7'd0, 2'b01, 64'hE0);
    slot1(PIPE_ODD,  7'd50, 3'd2, 7'd52, 7'd0, 2'b01, 64'hE1);
    applyStimulus("waw", 2'b01);
    clearSlots();
    slot0(PIPE_ODD, 7'd50, 3'd2, 7'd52, 7'd0, 2'b01, 64'hE1);
    applyStimulus("waw_next", 2'b01);

    // Routing follows the pipe field, not the slot position.
    clearSlots();
    slot0(PIPE_ODD,  7'd55, 3'd2, 7'd57, 7'd0, 2'b01, 64'hE2);
    slot1(PIPE_EVEN, 7'd56, 3'd2, 7'd58, 7'd0, 2'b01, 64'hE3);
    applyStimulus("dual_swap", 2'b11);
    checkCounters("dual_swap", 8, 2);

    // Flush kills the pair; the scoreboard keeps counting down.
    clearSlots();
    slot0(PIPE_EVEN, 7'd60, LAT_SP_FP, 7'd70, 7'd0, 2'b01, 64'hF0);
    applyStimulus("prod_l6", 2'b01);
    clearSlots();
    flush = 1'b1;
    slot0(PIPE_EVEN, 7'd61, 3'd2, 7'd63, 7'd0, 2'b01, 64'hF1);
    slot1(PIPE_ODD,  7'd62, 3'd2, 7'd64, 7'd0, 2'b01, 64'hF2);
    applyStimulus("flush", 2'b00);
    checkCounters("flush", 8, 2);
    clearSlots();
    slot0(PIPE_EVEN, 7'd65, 3'd2, 7'd61, 7'd62, 2'b11, 64'hF3);
    applyStimulus("post_flush_ready", 2'b01);
    clearSlots();
    slot0(PIPE_ODD, 7'd66, 3'd2, 7'd60, 7'd0, 2'b01, 64'hF4);
    for (int i = 0; i < 3; i++) applyStimulus("flush_decay_wait", 2'b00);
    applyStimulus("flush_decay_issue", 2'b01);
    checkCounters("flush_decay", 11, 2);

    // Reset mid-operation wipes a pending countdown on r10.
    clearSlots();
    slot0(PIPE_EVEN, 7'd10, LAT_SP_FP, 7'd70, 7'd0, 2'b01, 64'h90);
    applyStimulus("prod_r10", 2'b01);
    clearSlots();
    reset = 1'b1;
    slot0(PIPE_ODD, 7'd12, 3'd2, 7'd10, 7'd0, 2'b01, 64'h91);
    #2;
    chk("mid_reset consume", dec_consume, 2'b00);
    @(posedge clk); #1;
    checkResetState("mid_reset");
    reset = 1'b0;
    applyStimulus("post_reset_reader", 2'b01);
    checkCounters("post_reset", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
